// File: rtl/fpu_pkg.sv
// Shared types for the FPU command issuer:
// opcodes, FSM states and the queued command bundle.
package fpu_pkg;

  localparam int CMD_DATA_W = 32;
  localparam int CMD_TAG_W  = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_MUL = 2'b01,
    OP_DIV = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  typedef struct packed {
    logic [CMD_DATA_W-1:0] a;
    logic [CMD_DATA_W-1:0] b;
    op_e                   opcode;
    logic [CMD_TAG_W-1:0]  tag;
  } cmd_t;

endpackage

// File: rtl/fpu_cmd_issuer_if.sv
// Command, FPU and response signals of the issuer.
// slave = issuer side, master = environment side.
interface fpu_cmd_issuer_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [1:0]        cmd_opcode;
  logic [TAG_W-1:0]  cmd_tag;

  logic [DATA_W-1:0] fpu_a;
  logic [DATA_W-1:0] fpu_b;
  logic [1:0]        fpu_opcode;
  logic              fpu_start;
  logic [DATA_W-1:0] fpu_result;
  logic              fpu_done;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_err;
  logic              busy;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b,
    input  cmd_opcode, cmd_tag,
    output cmd_ready,
    output fpu_a, fpu_b, fpu_opcode,
    output fpu_start,
    input  fpu_result, fpu_done,
    output rsp_valid, rsp_result,
    output rsp_tag, rsp_err,
    input  rsp_ready,
    output busy
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b,
    output cmd_opcode, cmd_tag,
    input  cmd_ready,
    input  fpu_a, fpu_b, fpu_opcode,
    input  fpu_start,
    output fpu_result, fpu_done,
    input  rsp_valid, rsp_result,
    input  rsp_tag, rsp_err,
    output rsp_ready,
    input  busy
  );

endinterface

// File: rtl/fpu_cmd_issuer_fifo.sv
// Synchronous command FIFO with wrapping pointers.
// Push is ignored while full, pop while empty.
module fpu_cmd_fifo
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  cmd_t wr_data,
  input  logic pop,
  output cmd_t rd_data,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        do_push && !do_pop: count <= count + 1'b1;
        do_pop && !do_push: count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fpu_cmd_issuer.sv
// FPU command front-end: queues commands, issues one at a time, returns tagged results.
// Define FPU_TIMEOUT_EN to enable the WAIT watchdog.
module fpu_cmd_issuer
  import fpu_pkg::*;
#(
  parameter int DATA_W      = CMD_DATA_W,
  parameter int TAG_W       = CMD_TAG_W,
  parameter int FIFO_DEPTH  = 4,
  parameter int SETTLE_CYC  = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input logic             clk,
  input logic             rst_n,
  fpu_cmd_issuer_if.slave io
);

  localparam int CNT_MAX =
    (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
  localparam int CW = $clog2(CNT_MAX + 1);

  state_e            state;
  state_e            state_d;
  cmd_t              wr_cmd;
  cmd_t              head;
  logic              full;
  logic              empty;
  logic              pop;
  logic              cap_ok;
  logic              cap_tmo;
  logic              clr_cnt;
  logic              done_hit;
  logic              tmo_hit;
  logic              tmo;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_inc;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] res_q;
  op_e               op_q;
  logic [TAG_W-1:0]  tag_q;
  logic              err_q;

  assign wr_cmd = '{
    a:      io.cmd_a,
    b:      io.cmd_b,
    opcode: op_e'(io.cmd_opcode),
    tag:    io.cmd_tag
  };

  fpu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (io.cmd_valid),
    .wr_data (wr_cmd),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  // cnt_inc counts WAIT cycles including the current one; saturates
  assign cnt_inc = (cnt == CW'(CNT_MAX)) ? cnt : cnt + 1'b1;

`ifdef FPU_TIMEOUT_EN
  assign tmo = (cnt_inc >= CW'(TIMEOUT_CYC));
`else
  assign tmo = 1'b0;
`endif

  assign done_hit = io.fpu_done && (cnt_inc >= CW'(SETTLE_CYC));
  assign tmo_hit  = tmo && !done_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    pop     = 1'b0;
    cap_ok  = 1'b0;
    cap_tmo = 1'b0;
    clr_cnt = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = (head.opcode == OP_RSV) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        clr_cnt = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        unique case (1'b1)
          done_hit: begin
            cap_ok  = 1'b1;
            state_d = RESP;
          end
          tmo_hit: begin
            cap_tmo = 1'b1;
            state_d = RESP;
          end
          default: ;
        endcase
      end
      RESP: begin
        if (io.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= OP_ADD;
      tag_q <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (clr_cnt)            cnt <= '0;
      else if (state == WAIT) cnt <= cnt_inc;
      if (pop) begin
        a_q   <= head.a;
        b_q   <= head.b;
        op_q  <= head.opcode;
        tag_q <= head.tag;
        res_q <= '0;
        err_q <= (head.opcode == OP_RSV);
      end
      if (cap_ok) begin
        res_q <= io.fpu_result;
        err_q <= 1'b0;
      end
      if (cap_tmo) begin
        res_q <= '0;
        err_q <= 1'b1;
      end
    end
  end

  assign io.cmd_ready  = !full;
  assign io.fpu_a      = a_q;
  assign io.fpu_b      = b_q;
  assign io.fpu_opcode = op_q;
  assign io.fpu_start  = (state == ISSUE);
  assign io.rsp_valid  = (state == RESP);
  assign io.rsp_result = res_q;
  assign io.rsp_tag    = tag_q;
  assign io.rsp_err    = err_q;
  assign io.busy       = (state != IDLE) || !empty;

endmodule
